// File: rtl/expand16_32_stream_pkg.sv
// Shared definitions for the 16<->32 bit sample conversion paths.
// The 32->16 truncator uses the same widths and fraction position.
package expand16_32_stream_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int WORD_W     = 32;
    localparam int FRAC_SHIFT = 9;

    // State names the sample currently presented on m_data.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OUT_LO = 2'd1,
        ST_OUT_HI = 2'd2
    } exp_state_e;
endpackage

// File: rtl/expand16_32_comb.sv
// Pure combinational expansion: sign-extend a 16-bit sample and place its LSB at bit FRAC_SHIFT.
module expand16_32_comb
    import expand16_32_stream_pkg::*;
#(
    parameter int FRAC_SHIFT_P = FRAC_SHIFT
) (
    input  logic [SAMPLE_W-1:0] x,
    output logic [WORD_W-1:0]   y
);
    assign y = {{(WORD_W - SAMPLE_W - FRAC_SHIFT_P){x[SAMPLE_W-1]}}, x, {FRAC_SHIFT_P{1'b0}}};
endmodule

// File: rtl/expand16_32_stream.sv
// Streams packed pairs of 16-bit samples out as 32-bit fixed-point samples, one per handshake.
// Registered output; the word's final sample may overlap with loading the next word.
module expand16_32_stream
    import expand16_32_stream_pkg::*;
#(
    parameter int FRAC_SHIFT_P = FRAC_SHIFT,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      s_data,
    input  logic             s_single,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] sample_cnt
);
    exp_state_e         state_q, state_d;
    logic [31:0]        m_data_q, m_data_d;
    logic               m_last_q, m_last_d;
    logic               m_valid_q, m_valid_d;
    logic [15:0]        hold_hi_q, hold_hi_d;
    logic               hold_single_q, hold_single_d;
    logic               hold_last_q, hold_last_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [31:0]        exp_lo, exp_hi;

    expand16_32_comb #(.FRAC_SHIFT_P(FRAC_SHIFT_P)) u_exp_lo (.x(s_data[15:0]), .y(exp_lo));
    expand16_32_comb #(.FRAC_SHIFT_P(FRAC_SHIFT_P)) u_exp_hi (.x(hold_hi_q),    .y(exp_hi));

    always_comb begin
        state_d       = state_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        m_valid_d     = m_valid_q;
        hold_hi_d     = hold_hi_q;
        hold_single_d = hold_single_q;
        hold_last_d   = hold_last_q;
        sample_cnt_d  = sample_cnt_q;
        s_ready       = 1'b0;

        case (state_q)
            ST_IDLE:   s_ready = 1'b1;
            ST_OUT_LO: s_ready = hold_single_q ? m_ready : 1'b0;
            ST_OUT_HI: s_ready = m_ready;
            default:   s_ready = 1'b0;
        endcase

        // Final sample of a word is leaving (or nothing is held): refill or drop to idle.
        if (state_q == ST_OUT_LO && !hold_single_q) begin
            if (m_ready) begin
                m_data_d = exp_hi;
                m_last_d = hold_last_q;
                state_d  = ST_OUT_HI;
            end
        end else if (state_q == ST_IDLE || m_ready) begin
            if (s_valid) begin
                m_data_d      = exp_lo;
                m_last_d      = s_single & s_last;
                m_valid_d     = 1'b1;
                hold_hi_d     = s_data[31:16];
                hold_single_d = s_single;
                hold_last_d   = s_last;
                state_d       = ST_OUT_LO;
            end else begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                state_d   = ST_IDLE;
            end
        end

        if (m_valid_q && m_ready)
            sample_cnt_d = m_last_q ? '0 : sample_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            m_data_q      <= '0;
            m_last_q      <= 1'b0;
            m_valid_q     <= 1'b0;
            hold_hi_q     <= '0;
            hold_single_q <= 1'b0;
            hold_last_q   <= 1'b0;
            sample_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
            m_valid_q     <= m_valid_d;
            hold_hi_q     <= hold_hi_d;
            hold_single_q <= hold_single_d;
            hold_last_q   <= hold_last_d;
            sample_cnt_q  <= sample_cnt_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign m_valid    = m_valid_q;
    assign sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_expand16_32_stream.sv
// Scoreboard bench: driver pushes expected samples on input handshake, monitor pops on output handshake.
module tb_expand16_32_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_single, s_last, s_valid, s_ready;
    logic [31:0] m_data;
    logic        m_last, m_valid, m_ready;
    logic [15:0] sample_cnt;

    expand16_32_stream dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_single(s_single), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic last; logic [15:0] x; } exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    int   cnt_m = 0;
    bit   in_rst = 1'b0;

    // Reference: value of the signed sample scaled by 2^9, as a 32-bit word.
    function automatic logic [31:0] ref_exp(input logic [15:0] x);
        int v;
        v = int'($signed(x)) * 512;
        return 32'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 9) < 7);
            default: m_ready = 1'b0;
        endcase
    end

    // Monitor: pops on every output handshake and checks AXI-style hold while stalled.
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (in_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", m_data, prev_data);
                check("stall_last", 32'(m_last), 32'(prev_last));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_sample: got %h with empty scoreboard", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.data);
                    check("m_last", 32'(m_last), 32'(e.last));
                    check("round_trip", 32'(m_data[24:9]), 32'(e.x));
                    check("sample_cnt", 32'(sample_cnt), 32'(cnt_m));
                    cnt_m = e.last ? 0 : cnt_m + 1;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit single, input bit last, output int waits);
        s_data = d; s_single = single; s_last = last; s_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waits++;
            if (waits > 200) begin
                n_cmp++; n_err++;
                $display("FAIL accept_timeout: s_ready stuck at %0d expected 1", s_ready);
                break;
            end
        end
        if (waits <= 200) begin
            exp_q.push_back('{ref_exp(d[15:0]), single & last, d[15:0]});
            if (!single) exp_q.push_back('{ref_exp(d[31:16]), last, d[31:16]});
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = $urandom; s_single = $urandom; s_last = $urandom;
    endtask

    initial begin
        int w;
        int to;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_single = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Directed pair and single-lane extremes with constant expectations.
        send(32'hFFFF_0001, 1'b0, 1'b1, w);
        @(negedge clk);
        check("t1_lo", m_data, 32'h0000_0200);
        check("t1_lo_last", 32'(m_last), 32'd0);
        @(negedge clk);
        check("t1_hi", m_data, 32'hFFFF_FE00);
        check("t1_hi_last", 32'(m_last), 32'd1);
        check("t1_hi_cnt", 32'(sample_cnt), 32'd1);
        @(posedge clk); #1;
        send(32'hABCD_7FFF, 1'b1, 1'b0, w);
        @(negedge clk);
        check("t2_max", m_data, 32'h00FF_FE00);
        @(posedge clk); #1;
        send(32'h0000_8000, 1'b1, 1'b1, w);
        @(negedge clk);
        check("t2_min", m_data, 32'hFF00_0000);
        @(posedge clk); #1;

        // Back-to-back pairs: each following word accepted exactly two clocks later.
        for (int i = 0; i < 4; i++) begin
            send($urandom, 1'b0, (i == 3), w);
            if (i > 0) check("b2b_accept_gap", 32'(w), 32'd1);
        end
        repeat (3) @(posedge clk); #1;

        // Stall five clocks in OUT_LO.
        ready_mode = 2;
        @(posedge clk); #1;
        send(32'h5555_A5A5, 1'b0, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_s_ready", 32'(s_ready), 32'd0);
            check("stall_lo_data", m_data, 32'hFF4B_4A00);
        end
        ready_mode = 0;
        repeat (4) @(posedge clk); #1;

        // Reset while the lo lane is presented; hi lane must never appear.
        ready_mode = 2;
        @(posedge clk); #1;
        send(32'h1234_0002, 1'b0, 1'b1, w);
        in_rst = 1'b1; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete(); cnt_m = 0;
        @(negedge clk);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_data", m_data, 32'd0);
        check("mid_rst_cnt", 32'(sample_cnt), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd1);
        in_rst = 1'b0;
        ready_mode = 0;
        @(posedge clk); #1;

        // Random traffic with random backpressure and input gaps.
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send($urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0), w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_mode = 0;
        to = 0;
        while (exp_q.size() != 0 && to < 1000) begin
            @(posedge clk); to++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
